// File: rtl/reduction_tree_ctrl_if.sv
// Host/datapath handshake bundle for the reduction tree sequencer.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
interface reduction_tree_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             abort;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_idx;
    logic             fp_en;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_idx;

    // Host / operand source / result sink side
    modport master (
        output start, num_ops, abort, in_valid, out_ready,
        input  busy, done, in_ready, in_idx, fp_en, out_valid, out_idx
    );

    // Sequencer side
    modport slave (
        input  start, num_ops, abort, in_valid, out_ready,
        output busy, done, in_ready, in_idx, fp_en, out_valid, out_idx
    );
endinterface

// File: rtl/reduction_tree_ctrl.sv
// Sequencer for the 64-lane multiply/adder-tree dot-product datapath.
// Latency: operands accepted at edge t give a result in cycle t+LAT (LAT = MUL_LAT+6*ADD_LAT).
// Backpressure: out_valid && !out_ready drops fp_en, freezing datapath, tracking SR and input.
module reduction_tree_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    reduction_tree_ctrl_if.slave  bus
);
    localparam int LAT = MUL_LAT + 6 * ADD_LAT;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]          num_ops_q;
    logic [CNT_W-1:0]          issued_q;
    logic [CNT_W-1:0]          retired_q;
    logic [LAT-1:0]            vld_sr;
    logic [LAT-1:0][CNT_W-1:0] tag_sr;

    logic out_valid;
    logic fp_en;
    logic in_ready;
    logic accept;
    logic retire;
    logic last_issue;
    logic last_retire;
    logic load_job;
    logic clear_job;

    // The tail of the tracking SR lines up with the datapath output stage.
    assign out_valid   = vld_sr[LAT-1];
    assign fp_en       = !(out_valid && !bus.out_ready);
    assign in_ready    = (state_q == RUN) && (issued_q < num_ops_q) && fp_en;
    assign accept      = bus.in_valid && in_ready;
    assign retire      = out_valid && bus.out_ready;
    assign last_issue  = accept && ((issued_q + ONE) == num_ops_q);
    assign last_retire = retire && ((retired_q + ONE) == num_ops_q);

    assign bus.out_valid = out_valid;
    assign bus.out_idx   = tag_sr[LAT-1];
    assign bus.fp_en     = fp_en;
    assign bus.in_ready  = in_ready;
    assign bus.in_idx    = issued_q;
    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job sequencing: start is only seen in IDLE, abort only in RUN/DRAIN.
    always_comb begin
        state_d   = state_q;
        load_job  = 1'b0;
        clear_job = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_job = 1'b1;
                    state_d  = (bus.num_ops == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    clear_job = 1'b1;
                    state_d   = IDLE;
                end else if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    clear_job = 1'b1;
                    state_d   = IDLE;
                end else if (last_retire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job size latch and issue/retire counters; accept and retire may both land in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_ops_q <= '0;
            issued_q  <= '0;
            retired_q <= '0;
        end else if (load_job) begin
            num_ops_q <= bus.num_ops;
            issued_q  <= '0;
            retired_q <= '0;
        end else if (clear_job) begin
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            if (accept) begin
                issued_q <= issued_q + ONE;
            end
            if (retire && (retired_q < num_ops_q)) begin
                retired_q <= retired_q + ONE;
            end
        end
    end

    // Valid tracking: advances with the datapath; abort marks everything in flight invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else if (clear_job) begin
            vld_sr <= '0;
        end else if (fp_en) begin
            vld_sr <= {vld_sr[LAT-2:0], accept};
        end
    end

    // Tag tracking: op index travels alongside its operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_sr <= '0;
        end else if (fp_en) begin
            tag_sr <= {tag_sr[LAT-2:0], issued_q};
        end
    end
endmodule
